imm_inst_encoder: RTL and testbench

//  Inverse of the decode-side immediate extraction: packs {opcode, regs, funct, 64-bit imm} into a 32-bit RV64 instruction.
//  Two-stage valid/ready pipeline feeding the NPC self-test instruction injector (difftest stimulus, trap/ebreak stubs).

---
 rtl/imm_inst_encoder_pkg.sv | 29 ++
 rtl/imm_inst_encoder_if.sv | 31 +++
 rtl/imm_inst_encoder_imm_pack.sv | 61 ++++++
 rtl/imm_inst_encoder.sv | 97 +++++++++
 tb/tb_imm_inst_encoder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_inst_encoder_pkg.sv
// npc_isa_pkg: RV64 opcode constants, instruction format enum and opcode-to-format lookup
// Shared by the encoder top and its packing sub-module.
package npc_isa_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} inst_fmt_e;

  function automatic inst_fmt_e opcodeFmt(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC:                     return FMT_U;
      OP_JAL:                               return FMT_J;
      OP_BRANCH:                            return FMT_B;
      OP_JALR, OP_LOAD, OP_IMM, OP_IMM32:   return FMT_I;
      OP_STORE:                             return FMT_S;
      OP_REG, OP_REG32:                     return FMT_R;
      default:                              return FMT_BAD;
    endcase
  endfunction
endpackage

// File: rtl/imm_inst_encoder_if.sv
// imm_inst_encoder_if: request/response handshake bundle of the immediate instruction encoder
// Ports: in_* request channel (valid/ready + decoded fields), out_* encoded instruction channel.
// master = request producer / result consumer, slave = the encoder.
interface imm_inst_encoder_if #(
  parameter int INST_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [6:0]            in_opcode;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [DATA_WIDTH-1:0] in_imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [INST_WIDTH-1:0] out_inst;
  logic                  out_err;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/imm_inst_encoder_imm_pack.sv
// imm_pack: combinational packer of opcode, register fields and immediate into a 32-bit RV64 instruction
// Ports: opcode/rd/rs1/rs2/funct3/funct7/imm in; inst (packed instruction), err (imm out of range or unknown opcode) out.
module imm_pack
  import npc_isa_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [31:0]           inst,
  output logic                  err
);
  inst_fmt_e fmt;
  logic fitsI, fitsB, fitsJ, fitsU;
  assign fmt = opcodeFmt(opcode);
  // An immediate fits an N-bit signed field when every bit from the field's sign bit up is identical.
  assign fitsI = &imm[DATA_WIDTH-1:11] | ~|imm[DATA_WIDTH-1:11];
  assign fitsB = (&imm[DATA_WIDTH-1:12] | ~|imm[DATA_WIDTH-1:12]) & ~imm[0];
  assign fitsJ = (&imm[DATA_WIDTH-1:20] | ~|imm[DATA_WIDTH-1:20]) & ~imm[0];
  assign fitsU = (&imm[DATA_WIDTH-1:31] | ~|imm[DATA_WIDTH-1:31]) & ~|imm[11:0];
  // Out-of-range immediates are still packed from their truncated bits; only an unknown opcode yields inst=0.
  always_comb begin
    inst = '0;
    err  = 1'b1;
    case (fmt)
      FMT_I: begin
        inst = {imm[11:0], rs1, funct3, rd, opcode};
        err  = ~fitsI;
      end
      FMT_S: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = ~fitsI;
      end
      FMT_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = ~fitsB;
      end
      FMT_U: begin
        inst = {imm[31:12], rd, opcode};
        err  = ~fitsU;
      end
      FMT_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = ~fitsJ;
      end
      FMT_R: begin
        inst = {funct7, rs2, rs1, funct3, rd, opcode};
        err  = 1'b0;
      end
      default: begin
        inst = '0;
        err  = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/imm_inst_encoder.sv
// imm_inst_encoder: two-stage valid/ready pipeline packing decoded fields into RV64 instructions
// Ports: clk; rst_n (async, active-low); bus (slave: in_* request channel, out_* encoded instruction + err);
//        enc_cnt = output handshakes since reset, err_cnt = output handshakes carrying out_err (both wrap).
// Only INST_WIDTH = 32 is supported.
module imm_inst_encoder
  import npc_isa_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_inst_encoder_if.slave    bus,
  output logic [CNT_WIDTH-1:0] enc_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);
  logic                  s1Valid, s2Valid, s1Ready, s2Ready, inFire, outFire;
  logic [6:0]            s1Opcode, s1Funct7;
  logic [4:0]            s1Rd, s1Rs1, s1Rs2;
  logic [2:0]            s1Funct3;
  logic [DATA_WIDTH-1:0] s1Imm;
  logic [31:0]           packInst;
  logic                  packErr;
  logic [INST_WIDTH-1:0] s2Inst;
  logic                  s2Err;

  // Each stage can take new data when empty or when its contents move on this edge.
  assign s2Ready       = !s2Valid || bus.out_ready;
  assign s1Ready       = !s1Valid || s2Ready;
  assign inFire        = bus.in_valid && s1Ready;
  assign outFire       = s2Valid && bus.out_ready;
  assign bus.in_ready  = s1Ready;
  assign bus.out_valid = s2Valid;
  assign bus.out_inst  = s2Inst;
  assign bus.out_err   = s2Err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid  <= 1'b0;
      s1Opcode <= '0;
      s1Rd     <= '0;
      s1Rs1    <= '0;
      s1Rs2    <= '0;
      s1Funct3 <= '0;
      s1Funct7 <= '0;
      s1Imm    <= '0;
    end else begin
      if (s1Ready) s1Valid <= bus.in_valid;
      if (inFire) begin
        s1Opcode <= bus.in_opcode;
        s1Rd     <= bus.in_rd;
        s1Rs1    <= bus.in_rs1;
        s1Rs2    <= bus.in_rs2;
        s1Funct3 <= bus.in_funct3;
        s1Funct7 <= bus.in_funct7;
        s1Imm    <= bus.in_imm;
      end
    end
  end

  imm_pack #(.DATA_WIDTH(DATA_WIDTH)) u_pack (
    .opcode(s1Opcode),
    .rd    (s1Rd),
    .rs1   (s1Rs1),
    .rs2   (s1Rs2),
    .funct3(s1Funct3),
    .funct7(s1Funct7),
    .imm   (s1Imm),
    .inst  (packInst),
    .err   (packErr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid <= 1'b0;
      s2Inst  <= '0;
      s2Err   <= 1'b0;
    end else if (s2Ready) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Inst <= packInst;
        s2Err  <= packErr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (outFire) begin
      enc_cnt <= enc_cnt + CNT_WIDTH'(1);
      if (s2Err) err_cnt <= err_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_imm_inst_encoder.sv
// tb_imm_inst_encoder: scoreboard bench for the two-stage immediate instruction encoder
module tb_imm_inst_encoder;
  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] encCnt, errCnt;
  exp_t        sb[$];
  exp_t        monE;
  int          nVec, nMis, nOut, nErrOut;
  bit          rndDone;

  imm_inst_encoder_if #(.INST_WIDTH(32), .DATA_WIDTH(64)) bus ();

  imm_inst_encoder #(.INST_WIDTH(32), .DATA_WIDTH(64), .CNT_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .enc_cnt(encCnt),
    .err_cnt(errCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder working from the signed value of the immediate.
  function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [63:0] imm);
    exp_t r;
    longint s;
    s = longint'(imm);
    r.inst = '0;
    r.err  = 1'b0;
    case (op)
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
        r.inst = {imm[11:0], rs1, f3, rd, op};
        r.err  = s < -64'sd2048 || s > 64'sd2047;
      end
      7'b0100011: begin
        r.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        r.err  = s < -64'sd2048 || s > 64'sd2047;
      end
      7'b1100011: begin
        r.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        r.err  = s < -64'sd4096 || s > 64'sd4095 || imm[0];
      end
      7'b1101111: begin
        r.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        r.err  = s < -64'sd1048576 || s > 64'sd1048575 || imm[0];
      end
      7'b0110111, 7'b0010111: begin
        r.inst = {imm[31:12], rd, op};
        r.err  = s < -64'sd2147483648 || s > 64'sd2147483647 || imm[11:0] != 12'h0;
      end
      7'b0110011, 7'b0111011: r.inst = {f7, rs2, rs1, f3, rd, op};
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(op, rd, rs1, rs2, f3, f7, imm));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check("unexpected_out", 64'd1, 64'd0);
      else begin
        monE = sb.pop_front();
        check("out_inst", 64'(bus.out_inst), 64'(monE.inst));
        check("out_err", 64'(bus.out_err), 64'(monE.err));
        nOut++;
        if (monE.err) nErrOut++;
      end
    end
  end

  logic [6:0] ops [13] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                           7'b0100011, 7'b0010011, 7'b0011011, 7'b0110011, 7'b0111011, 7'h7F, 7'h00};

  initial begin
    int lat, run;
    logic [63:0] imm;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_funct3 = '0;
    bus.in_funct7 = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_inst", 64'(bus.out_inst), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    check("rst_enc_cnt", 64'(encCnt), 64'd0);
    check("rst_err_cnt", 64'(errCnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // addi x1, x0, -1 and its latency: accept cycle is 0, output expected in cycle 2
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    check("latency", 64'(lat), 64'd2);
    check("addi_const", 64'(bus.out_inst), 64'hFFF00093);
    @(posedge clk);
    #1;

    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd8);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000);
    drain();
    check("err_cnt_none", 64'(errCnt), 64'd0);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
    drain();
    check("err_cnt_addi", 64'(errCnt), 64'd1);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3);
    send(7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd2, 64'd0);
    send(7'b0110011, 5'd3, 5'd4, 5'd5, 3'd7, 7'h20, 64'hDEAD_BEEF_0000_0001);
    drain();
    check("err_cnt_3", 64'(errCnt), 64'd3);
    check("enc_cnt_8", 64'(encCnt), 64'd8);

    // Stall: three requests against a blocked consumer, only two fit.
    bus.out_ready = 1'b0;
    fork
      begin
        send(7'b0010011, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 64'd5);
        send(7'b0100011, 5'd0, 5'd2, 5'd7, 3'd3, 7'd0, -64'sd16);
        send(7'b1100011, 5'd0, 5'd4, 5'd6, 3'd1, 7'd0, -64'sd4096);
      end
      begin
        repeat (3) @(negedge clk);
        repeat (2) begin
          @(negedge clk);
          check("stall_valid", 64'(bus.out_valid), 64'd1);
          check("stall_hold", 64'(bus.out_inst), 64'(sb[0].inst));
        end
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_sb_depth", 64'(sb.size()), 64'd2);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("enc_cnt_stall", 64'(encCnt), 64'd11);

    // Back-to-back: ten outputs on ten consecutive cycles.
    fork
      for (int i = 0; i < 10; i++) send(7'b0010011, 5'(i), 5'd1, 5'd0, 3'd0, 7'd0, 64'(i * 3));
      begin
        run = 0;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (bus.out_valid && bus.out_ready) run++;
          else if (run > 0) break;
        end
        check("b2b_run", 64'(run), 64'd10);
      end
    join
    drain();
    check("enc_cnt_b2b", 64'(encCnt), 64'd21);

    // Random requests with a flickering consumer.
    rndDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          case ($urandom_range(0, 3))
            0: imm = {$urandom, $urandom};
            1: imm = 64'(signed'(13'($urandom)));
            2: imm = 64'(signed'({$urandom_range(0, 1) ? 20'($urandom) : 20'h0, 12'h0}));
            default: imm = 64'(signed'({21'($urandom) & 21'h1FFFFE}));
          endcase
          send(ops[$urandom_range(0, 12)], 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
        end
        rndDone = 1'b1;
      end
      begin
        while (!rndDone) begin
          @(posedge clk);
          #1;
          bus.out_ready = $urandom_range(0, 3) != 0;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("enc_cnt_rnd", 64'(encCnt), 64'(nOut));
    check("err_cnt_rnd", 64'(errCnt), 64'(nErrOut));

    // Reset with a full pipe.
    bus.out_ready = 1'b0;
    send(7'b0010011, 5'd9, 5'd9, 5'd0, 3'd0, 7'd0, 64'd1);
    send(7'b0010011, 5'd9, 5'd9, 5'd0, 3'd0, 7'd0, 64'd5000);
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_inst", 64'(bus.out_inst), 64'd0);
    check("mid_rst_enc", 64'(encCnt), 64'd0);
    check("mid_rst_err", 64'(errCnt), 64'd0);
    sb.delete();
    nOut = 0;
    nErrOut = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    send(7'b0010111, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_8000_0000);
    drain();
    check("post_rst_enc", 64'(encCnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
